// File: rtl/sa_pkg.sv
// Shared parameters and FSM encoding for the systolic-array weight path.
package sa_pkg;
  localparam int SA_N      = 3;
  localparam int SA_DATA_W = 8;
  localparam int SA_ADDR_W = 6;
  localparam int SA_W_BASE = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } sa_state_t;
endpackage

// File: rtl/sa_fifo2.sv
// Two-entry FIFO; the caller guarantees no push when full
// unless a pop happens in the same cycle.
module sa_fifo2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop)
        r_rd_ptr <= ~r_rd_ptr;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sa_weight_fetch_streamer.sv
// Reads an N x N weight tile column-major from row-major SRAM
// and streams it out over valid/ready with a 2-entry credit buffer.
module sa_weight_fetch_streamer
  import sa_pkg::*;
#(
  parameter int DATA_W    = SA_DATA_W,
  parameter int ADDR_W    = SA_ADDR_W,
  parameter int N         = SA_N,
  parameter int BASE_ADDR = SA_W_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [3:0]        w_index,
  output logic              w_last
);
  localparam int NN = N * N;
  localparam int KW = $clog2(NN);
  localparam int CW = $clog2(N);
  localparam logic [KW-1:0]     K_LAST = KW'(NN - 1);
  localparam logic [CW-1:0]     R_LAST = CW'(N - 1);
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(N);

  sa_state_t         r_state;
  logic [CW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [KW-1:0]     r_k_issue;
  logic [KW-1:0]     r_k_inflight;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_full;
  logic                 w_empty;
  logic [1:0]           w_count;
  logic [2:0]           w_occ;
  logic [DATA_W+KW-1:0] w_head;
  logic [KW-1:0]        w_head_k;
  logic [7:0]           w_k8;

  sa_fifo2 #(.W(DATA_W + KW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({mem_rd_data, r_k_inflight}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_valid  = ~w_empty;
  assign w_pop    = w_valid & w_ready;
  assign w_push   = r_inflight & (~w_full | w_pop);
  assign w_data   = w_head[KW +: DATA_W];
  assign w_head_k = w_head[KW-1:0];
  assign w_k8     = 8'(w_head_k);
  assign w_index  = w_k8[3:0];
  assign w_last   = w_valid & (w_head_k == K_LAST);

  // Buffered plus in-flight may never exceed the two FIFO slots.
  assign w_occ   = {1'b0, w_count} + {2'b0, r_inflight};
  assign w_issue = (r_state == S_FETCH) &&
                   (w_occ < (3'd2 + {2'b0, w_pop}));

  assign mem_rd_en = w_issue;
  assign mem_addr  = r_addr;
  assign busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_k_issue    <= '0;
      r_k_inflight <= '0;
      r_addr       <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue)
        r_k_inflight <= r_k_issue;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_row     <= '0;
            r_col     <= '0;
            r_k_issue <= '0;
            r_addr    <= A_BASE;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_k_issue <= r_k_issue + 1'b1;
            // Row wrap rewinds to the top of the next column.
            if (r_row == R_LAST) begin
              r_row  <= '0;
              r_col  <= r_col + 1'b1;
              r_addr <= A_BASE + ADDR_W'(r_col) + 1'b1;
            end else begin
              r_row  <= r_row + 1'b1;
              r_addr <= r_addr + A_STEP;
            end
            if (r_k_issue == K_LAST)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last)
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_weight_fetch_streamer.sv
// Directed bench for sa_weight_fetch_streamer (N=3 base 0, N=2 base 16).
module tb_sa_weight_fetch_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst, start, w_ready;
  logic       busy, done, rd_en, wv, wl;
  logic [5:0] addr;
  logic [7:0] rdata, wd;
  logic [3:0] wi;

  logic       b_rst, b_start, b_ready;
  logic       b_busy, b_done, b_rd_en, b_wv, b_wl;
  logic [5:0] b_addr;
  logic [7:0] b_rdata, b_wd;
  logic [3:0] b_wi;

  int exp_a[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
  int exp_b[4] = '{16, 18, 17, 19};

  sa_weight_fetch_streamer dut (
    .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(rd_en), .mem_addr(addr), .mem_rd_data(rdata),
    .w_valid(wv), .w_ready(w_ready), .w_data(wd), .w_index(wi), .w_last(wl)
  );

  sa_weight_fetch_streamer #(.N(2), .BASE_ADDR(16)) dut_b (
    .clk(clk), .reset(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rdata),
    .w_valid(b_wv), .w_ready(b_ready), .w_data(b_wd), .w_index(b_wi), .w_last(b_wl)
  );

  always @(posedge clk) if (rd_en) rdata <= 8'hA0 + 8'(addr);
  always @(posedge clk) if (b_rd_en) b_rdata <= 8'hA0 + 8'(b_addr);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; b_rst = 1; start = 0; b_start = 0; w_ready = 0; b_ready = 0;
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, addr, wv, wd, wi, wl} !== 22'd0) begin
      errors++;
      $display("FAIL reset_a got %h exp 0", {busy, done, rd_en, addr, wv, wd, wi, wl});
    end
    checks++;
    if ({b_busy, b_done, b_rd_en, b_addr, b_wv, b_wd, b_wi, b_wl} !== 22'd0) begin
      errors++;
      $display("FAIL reset_b got %h exp 0", {b_busy, b_done, b_rd_en, b_addr, b_wv, b_wd, b_wi, b_wl});
    end
    step; rst = 0; b_rst = 0; step; step;
  endtask

  task automatic test_stream;
    logic e_rd, e_v, e_l, e_done, e_busy;
    logic [5:0] e_addr;
    logic [7:0] e_d;
    logic [3:0] e_i;
    w_ready = 1; start = 1; step; start = 0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      e_rd = (cyc <= 9);
      e_addr = '0;
      if (e_rd) e_addr = 6'(exp_a[cyc-1]);
      e_v = (cyc >= 3 && cyc <= 11);
      e_d = '0; e_i = '0;
      if (e_v) begin
        e_d = 8'hA0 + 8'(exp_a[cyc-3]);
        e_i = 4'(cyc - 3);
      end
      e_l = (cyc == 11);
      e_done = (cyc == 12);
      e_busy = (cyc >= 1 && cyc <= 11);
      checks++;
      if (rd_en !== e_rd || (e_rd && addr !== e_addr)) begin
        errors++;
        $display("FAIL stream_rd cyc %0d got en=%b a=%0d exp en=%b a=%0d", cyc, rd_en, addr, e_rd, e_addr);
      end
      checks++;
      if (wv !== e_v || (e_v && (wd !== e_d || wi !== e_i || wl !== e_l))) begin
        errors++;
        $display("FAIL stream_w cyc %0d got v=%b d=%h i=%0d l=%b exp v=%b d=%h i=%0d l=%b",
                 cyc, wv, wd, wi, wl, e_v, e_d, e_i, e_l);
      end
      checks++;
      if (done !== e_done || busy !== e_busy) begin
        errors++;
        $display("FAIL stream_ctl cyc %0d got done=%b busy=%b exp done=%b busy=%b",
                 cyc, done, busy, e_done, e_busy);
      end
      step;
    end
  endtask

  task automatic test_backpressure;
    int nrd, beats, last_cyc, done_cyc;
    logic [5:0] ra[2];
    nrd = 0; beats = 0; last_cyc = -1; done_cyc = -1;
    ra[0] = '1; ra[1] = '1;
    w_ready = 0; start = 1; step; start = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (rd_en) begin
        if (nrd < 2) ra[nrd] = addr;
        nrd++;
      end
      if (cyc >= 3) begin
        checks++;
        if (wv !== 1'b1 || wd !== 8'hA0 || wi !== 4'd0 || wl !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold cyc %0d got v=%b d=%h i=%0d l=%b exp v=1 d=a0 i=0 l=0",
                   cyc, wv, wd, wi, wl);
        end
      end
      step;
    end
    checks++;
    if (nrd != 2 || ra[0] !== 6'd0 || ra[1] !== 6'd3) begin
      errors++;
      $display("FAIL bp_reads got n=%0d a0=%0d a1=%0d exp n=2 a0=0 a1=3", nrd, ra[0], ra[1]);
    end
    w_ready = 1;
    for (int cyc = 21; cyc < 80 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (done) done_cyc = cyc;
      if (wv && w_ready) begin
        checks++;
        if (beats > 8 || wd !== 8'hA0 + 8'(exp_a[beats]) || wi !== 4'(beats) || wl !== (beats == 8)) begin
          errors++;
          $display("FAIL bp_beat %0d got d=%h i=%0d l=%b", beats, wd, wi, wl);
        end
        beats++;
        last_cyc = cyc;
      end
      step;
    end
    checks++;
    if (beats != 9 || done_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL bp_end got beats=%0d done_cyc=%0d last_cyc=%0d exp beats=9 done=last+1",
               beats, done_cyc, last_cyc);
    end
  endtask

  task automatic test_toggle;
    int issued, popped, ndone;
    logic pop;
    issued = 0; popped = 0; ndone = 0;
    w_ready = 1; start = 1; step; start = 0;
    for (int cyc = 1; cyc < 80 && ndone == 0; cyc++) begin
      w_ready = (cyc % 2 == 1);
      @(negedge clk);
      pop = wv && w_ready;
      if (done) ndone++;
      if (rd_en) begin
        checks++;
        if (issued - popped - int'(pop) >= 2) begin
          errors++;
          $display("FAIL tog_credit cyc %0d got occ=%0d pop=%b exp occ-pop<2",
                   cyc, issued - popped, pop);
        end
        issued++;
      end
      if (pop) begin
        checks++;
        if (popped > 8 || wd !== 8'hA0 + 8'(exp_a[popped]) || wi !== 4'(popped)) begin
          errors++;
          $display("FAIL tog_beat %0d got d=%h i=%0d", popped, wd, wi);
        end
        popped++;
      end
      step;
    end
    checks++;
    if (issued != 9 || popped != 9 || ndone != 1) begin
      errors++;
      $display("FAIL tog_end got iss=%0d pop=%0d done=%0d exp 9 9 1", issued, popped, ndone);
    end
    w_ready = 1;
  endtask

  task automatic test_start_ignored;
    int nrd, ndone, beats, done_cyc;
    nrd = 0; ndone = 0; beats = 0; done_cyc = -1;
    w_ready = 1; start = 1; step;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      start = (cyc <= 12);
      @(negedge clk);
      if (rd_en) nrd++;
      if (wv) beats++;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      step;
    end
    start = 0;
    checks++;
    if (nrd != 9 || beats != 9 || ndone != 1 || done_cyc != 12) begin
      errors++;
      $display("FAIL start_ign got rd=%0d beats=%0d done=%0d@%0d exp 9 9 1@12",
               nrd, beats, ndone, done_cyc);
    end
  endtask

  task automatic test_reset_mid;
    int beats, first_cyc, nrd;
    logic [5:0] first_addr;
    beats = 0; first_cyc = -1; nrd = 0; first_addr = '1;
    w_ready = 1; start = 1; step; start = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (wv) beats++;
      step;
    end
    checks++;
    if (beats != 4) begin
      errors++;
      $display("FAIL rmid_pre got beats=%0d exp 4", beats);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, addr, wv, wd, wi, wl} !== 22'd0) begin
      errors++;
      $display("FAIL rmid_reset got %h exp 0", {busy, done, rd_en, addr, wv, wd, wi, wl});
    end
    step; rst = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if (wv !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL rmid_idle got v=%b rd=%b exp 0 0", wv, rd_en);
      end
      step;
    end
    beats = 0;
    start = 1; step; start = 0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      if (rd_en) begin
        if (nrd == 0) first_addr = addr;
        nrd++;
      end
      if (wv) begin
        if (first_cyc < 0) first_cyc = cyc;
        checks++;
        if (beats > 8 || wd !== 8'hA0 + 8'(exp_a[beats]) || wi !== 4'(beats)) begin
          errors++;
          $display("FAIL rmid_beat %0d got d=%h i=%0d", beats, wd, wi);
        end
        beats++;
      end
      step;
    end
    checks++;
    if (first_addr !== 6'd0 || first_cyc != 3 || beats != 9 || nrd != 9) begin
      errors++;
      $display("FAIL rmid_tile got a=%0d first=%0d beats=%0d rd=%0d exp 0 3 9 9",
               first_addr, first_cyc, beats, nrd);
    end
  endtask

  task automatic test_n2;
    logic e_rd, e_v, e_l, e_done;
    logic [5:0] e_addr;
    logic [7:0] e_d;
    logic [3:0] e_i;
    b_ready = 1; b_start = 1; step; b_start = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      e_rd = (cyc <= 4);
      e_addr = '0;
      if (e_rd) e_addr = 6'(exp_b[cyc-1]);
      e_v = (cyc >= 3 && cyc <= 6);
      e_d = '0; e_i = '0;
      if (e_v) begin
        e_d = 8'hA0 + 8'(exp_b[cyc-3]);
        e_i = 4'(cyc - 3);
      end
      e_l = (cyc == 6);
      e_done = (cyc == 7);
      checks++;
      if (b_rd_en !== e_rd || (e_rd && b_addr !== e_addr)) begin
        errors++;
        $display("FAIL n2_rd cyc %0d got en=%b a=%0d exp en=%b a=%0d", cyc, b_rd_en, b_addr, e_rd, e_addr);
      end
      checks++;
      if (b_wv !== e_v || (e_v && (b_wd !== e_d || b_wi !== e_i || b_wl !== e_l))) begin
        errors++;
        $display("FAIL n2_w cyc %0d got v=%b d=%h i=%0d l=%b exp v=%b d=%h i=%0d l=%b",
                 cyc, b_wv, b_wd, b_wi, b_wl, e_v, e_d, e_i, e_l);
      end
      checks++;
      if (b_done !== e_done) begin
        errors++;
        $display("FAIL n2_done cyc %0d got %b exp %b", cyc, b_done, e_done);
      end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    step;
    test_toggle;
    step;
    test_start_ignored;
    test_reset_mid;
    step;
    test_n2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
